// File: rtl/led_fade_pwm_if.sv
// LED fade stage bus: on/off pattern and fade control in, PWM drive and busy flag out.
interface led_fade_pwm_if #(
    parameter int N_LED = 4
);
    logic [N_LED-1:0] led_in;
    logic             fade_en;
    logic [N_LED-1:0] led_out;
    logic             busy;

    // Pattern source (blinker side / bench)
    modport master (
        output led_in,
        output fade_en,
        input  led_out,
        input  busy
    );

    // Fade/PWM stage
    modport slave (
        input  led_in,
        input  fade_en,
        output led_out,
        output busy
    );
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: per-channel brightness ramp plus PWM dimmer between the blinker
// pattern and the LED pads. Each channel walks its duty one step per prescaler
// tick toward full-on or full-off; fade_en low makes duty follow the target directly.
module led_fade_pwm #(
    parameter int N_LED    = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 19531
) (
    input  logic          clk_50mhz,
    input  logic          rst,
    led_fade_pwm_if.slave bus
);
    localparam int MAX_DUTY_INT = (1 << PWM_BITS) - 1;
    localparam logic [PWM_BITS-1:0] MAX_DUTY = PWM_BITS'(MAX_DUTY_INT);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX_DUTY_INT - 1);

    // A divider of 1 still needs a 1-bit counter that simply stays at 0.
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

    // Implicit per-channel ramp direction, derived from duty vs target.
    typedef enum logic [1:0] {
        STEADY  = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } ch_dir_t;

    logic [N_LED-1:0]    led_in_q_reg;
    logic [SW-1:0]       step_cnt_reg;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [N_LED-1:0]    pwm_on;
    logic [N_LED-1:0]    led_out_reg;
    logic [N_LED-1:0]    ch_busy;

    // Register the incoming pattern once; all targets derive from this copy.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            led_in_q_reg <= '0;
        end else begin
            led_in_q_reg <= bus.led_in;
        end
    end

    assign tick = (step_cnt_reg == STEP_LAST);

    // Fade-step prescaler: counts 0..STEP_DIV-1, tick marks the last count.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            step_cnt_reg <= '0;
        end else if (tick) begin
            step_cnt_reg <= '0;
        end else begin
            step_cnt_reg <= step_cnt_reg + SW'(1);
        end
    end

    // PWM period counter: 0..MAX_DUTY-1 so duty MAX_DUTY is solidly on.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
        end else if (pwm_cnt_reg == PWM_LAST) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_LED; gi++) begin : g_ch
            logic [PWM_BITS-1:0] target;
            logic [PWM_BITS-1:0] duty_reg;
            logic [PWM_BITS-1:0] duty_next;
            ch_dir_t             dir;

            assign target = led_in_q_reg[gi] ? MAX_DUTY : '0;

            // Direction of travel; a reversal simply flips this on the next compare.
            always_comb begin
                dir = STEADY;
                if (duty_reg < target) begin
                    dir = RISING;
                end else if (duty_reg > target) begin
                    dir = FALLING;
                end
            end

            // Next duty: snap when fading is off, else one step per tick toward target.
            always_comb begin
                duty_next = duty_reg;
                if (!bus.fade_en) begin
                    duty_next = target;
                end else if (tick) begin
                    case (dir)
                        RISING:  duty_next = duty_reg + PWM_BITS'(1);
                        FALLING: duty_next = duty_reg - PWM_BITS'(1);
                        default: duty_next = duty_reg;
                    endcase
                end
            end

            // Duty register; never leaves 0..MAX_DUTY since it only moves toward an endpoint.
            always_ff @(posedge clk_50mhz or posedge rst) begin
                if (rst) begin
                    duty_reg <= '0;
                end else begin
                    duty_reg <= duty_next;
                end
            end

            assign pwm_on[gi]  = (pwm_cnt_reg < duty_reg);
            assign ch_busy[gi] = (dir != STEADY);
        end
    endgenerate

    // Registered LED drive, one cycle behind duty and pwm_cnt.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            led_out_reg <= '0;
        end else begin
            led_out_reg <= pwm_on;
        end
    end

    assign bus.led_out = led_out_reg;
    assign bus.busy    = |ch_busy;

endmodule
